spr_linebuf: RTL and testbench

- Double-buffered sprite line buffer sitting directly upstream of the video timing generator.
- The sprite engine writes colour indices for line N+1 into the back bank while the front bank is read out at the generator's HPOS to form the pixel stream for line N.
- The output is registered and feeds the timing generator's iRGB input.
- Front-bank pixels are cleared as they are read, so the bank is empty when it becomes the back bank.

---
 rtl/spr_linebuf.sv | 188 ++++++++++++++++++
 tb/tb_spr_linebuf.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/spr_linebuf.sv
// Double-buffered 2x256x8 sprite line buffer: back bank written first-opaque-wins, front bank read at HPOS and cleared on read.
// Optional per-line write limit and OVFL flag enabled by defining LINEBUF_OVFL_EN.
module spr_linebuf #(
    parameter int HOFS     = 1,
    parameter int LINE_END = 395,
    parameter int MAXW     = 128
) (
    input  logic       PCLK,
    input  logic       RST_N,
    input  logic [8:0] HPOS,
    input  logic [8:0] VPOS,
    input  logic       WR_EN,
    input  logic [8:0] WR_X,
    input  logic [7:0] WR_COL,
    output logic [7:0] oPIX,
    output logic       LSTART,
    output logic [8:0] oLINE,
    output logic       READY,
    output logic       OVFL
);
    localparam logic [8:0] HOFS_V     = 9'(HOFS);
    localparam logic [8:0] LINE_END_V = 9'(LINE_END);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t     state_q, state_d;
    logic [7:0] clr_cnt_q, clr_cnt_d;
    logic       sel_q, sel_d;
    logic [7:0] pix_q, pix_d;
    logic       lstart_q, lstart_d;
    logic [8:0] line_q, line_d;
    logic       ready_q, ready_d;

    logic [7:0] bank0_q [256];
    logic [7:0] bank1_q [256];

    logic       run, rd_valid, swap, wr_cand, wr_drop, wr_ok;
    logic [8:0] rd_addr;
    logic [7:0] front_cur, back_cur;
    logic       bank0_we, bank1_we;
    logic [7:0] bank0_wa, bank1_wa, bank0_wd, bank1_wd;
    logic       unused_bits;

    assign unused_bits = VPOS[8] ^ (MAXW == 0);

    // A write is only accepted into an empty back-bank slot, so the first opaque sprite wins.
    always_comb begin
        run       = (state_q == ST_RUN);
        rd_addr   = HPOS - HOFS_V;
        rd_valid  = run && !rd_addr[8];
        swap      = run && (HPOS == LINE_END_V);
        wr_cand   = run && WR_EN && !WR_X[8];
        front_cur = sel_q ? bank1_q[rd_addr[7:0]] : bank0_q[rd_addr[7:0]];
        back_cur  = sel_q ? bank0_q[WR_X[7:0]] : bank1_q[WR_X[7:0]];
        wr_ok     = wr_cand && !wr_drop && (WR_COL != 8'd0) && (back_cur == 8'd0);
    end

    // Each bank is either front (clear-on-read) or back (sprite write), so one write port per bank suffices.
    always_comb begin
        bank0_we = 1'b0;
        bank0_wa = 8'd0;
        bank0_wd = 8'd0;
        bank1_we = 1'b0;
        bank1_wa = 8'd0;
        bank1_wd = 8'd0;
        if (!run) begin
            bank0_we = 1'b1;
            bank0_wa = clr_cnt_q;
            bank1_we = 1'b1;
            bank1_wa = clr_cnt_q;
        end else begin
            if (rd_valid) begin
                if (sel_q) begin
                    bank1_we = 1'b1;
                    bank1_wa = rd_addr[7:0];
                end else begin
                    bank0_we = 1'b1;
                    bank0_wa = rd_addr[7:0];
                end
            end
            if (wr_ok) begin
                if (sel_q) begin
                    bank0_we = 1'b1;
                    bank0_wa = WR_X[7:0];
                    bank0_wd = WR_COL;
                end else begin
                    bank1_we = 1'b1;
                    bank1_wa = WR_X[7:0];
                    bank1_wd = WR_COL;
                end
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (RST_N && bank0_we) bank0_q[bank0_wa] <= bank0_wd;
        if (RST_N && bank1_we) bank1_q[bank1_wa] <= bank1_wd;
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        sel_d     = sel_q;
        pix_d     = 8'd0;
        lstart_d  = swap;
        line_d    = line_q;
        ready_d   = ready_q;
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 8'd1;
                if (clr_cnt_q == 8'hFF) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (rd_valid) pix_d = front_cur;
                if (swap) begin
                    sel_d  = ~sel_q;
                    line_d = {1'b0, VPOS[7:0] + 8'd2};
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!RST_N) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= 8'd0;
            sel_q     <= 1'b0;
            pix_q     <= 8'd0;
            lstart_q  <= 1'b0;
            line_q    <= 9'd0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            sel_q     <= sel_d;
            pix_q     <= pix_d;
            lstart_q  <= lstart_d;
            line_q    <= line_d;
            ready_q   <= ready_d;
        end
    end

`ifdef LINEBUF_OVFL_EN
    localparam logic [8:0] MAXW_V = 9'(MAXW);

    logic [8:0] wcnt_q, wcnt_d;
    logic       ovfl_q, ovfl_d;

    assign wr_drop = (wcnt_q >= MAXW_V);

    // The counter saturates at the limit; the flag marks that at least one write was dropped this line.
    always_comb begin
        wcnt_d = wcnt_q;
        ovfl_d = ovfl_q;
        if (wr_cand && !wr_drop) wcnt_d = wcnt_q + 9'd1;
        if (wr_cand && wr_drop)  ovfl_d = 1'b1;
        if (swap || !run) begin
            wcnt_d = 9'd0;
            ovfl_d = 1'b0;
        end
    end

    always_ff @(posedge PCLK) begin
        if (!RST_N) begin
            wcnt_q <= 9'd0;
            ovfl_q <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            ovfl_q <= ovfl_d;
        end
    end

    assign OVFL = ovfl_q;
`else
    assign wr_drop = 1'b0;
    assign OVFL    = 1'b0;
`endif

    assign oPIX   = pix_q;
    assign LSTART = lstart_q;
    assign oLINE  = line_q;
    assign READY  = ready_q;

endmodule

// File: tb/tb_spr_linebuf.sv
// Directed self-checking bench for spr_linebuf: clear sweep, swap/LSTART/oLINE, write priority, clear-on-read, reset mid-line.
// Adapts the write-limit expectations when LINEBUF_OVFL_EN is defined.
module tb_spr_linebuf;
    logic       PCLK = 1'b0;
    logic       RST_N;
    logic [8:0] HPOS, VPOS;
    logic       WR_EN;
    logic [8:0] WR_X;
    logic [7:0] WR_COL;
    logic [7:0] oPIX;
    logic       LSTART;
    logic [8:0] oLINE;
    logic       READY, OVFL;

    int checks = 0;
    int errors = 0;

`ifdef LINEBUF_OVFL_EN
    localparam int TB_MAXW = 4;
`else
    localparam int TB_MAXW = 128;
`endif

    spr_linebuf #(.HOFS(1), .LINE_END(395), .MAXW(TB_MAXW)) dut (
        .PCLK(PCLK), .RST_N(RST_N), .HPOS(HPOS), .VPOS(VPOS),
        .WR_EN(WR_EN), .WR_X(WR_X), .WR_COL(WR_COL),
        .oPIX(oPIX), .LSTART(LSTART), .oLINE(oLINE), .READY(READY), .OVFL(OVFL)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        int         h;
        logic [8:0] x;
        logic [7:0] col;
    } wr_t;

    wr_t        sched[$];
    logic [7:0] exp_pix [256];
    int         ovfl_from;

    task automatic checkOutput(input string tag, input logic [8:0] observed, input logic [8:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after the edge, so outputs are sampled away from it too.
    task automatic applyStimulus(input int h, input int v, input logic we, input logic [8:0] x, input logic [7:0] col);
        HPOS   = 9'(h);
        VPOS   = 9'(v);
        WR_EN  = we;
        WR_X   = x;
        WR_COL = col;
        @(posedge PCLK);
        #1;
    endtask

    task automatic clearExp();
        foreach (exp_pix[i]) exp_pix[i] = 8'h00;
        ovfl_from = -1;
    endtask

    task automatic addWrite(input int h, input logic [8:0] x, input logic [7:0] col);
        wr_t w;
        w.h   = h;
        w.x   = x;
        w.col = col;
        sched.push_back(w);
    endtask

    task automatic doLine(input int v, input int last_h);
        logic       we;
        logic [8:0] x;
        logic [7:0] col;
        logic [7:0] pe;
        logic       ov;
        for (int h = 0; h <= last_h; h++) begin
            we  = 1'b0;
            x   = 9'd0;
            col = 8'd0;
            foreach (sched[i]) begin
                if (sched[i].h == h) begin
                    we  = 1'b1;
                    x   = sched[i].x;
                    col = sched[i].col;
                end
            end
            applyStimulus(h, v, we, x, col);
            pe = (h >= 1 && h <= 256) ? exp_pix[h-1] : 8'h00;
            ov = (ovfl_from >= 0) && (h >= ovfl_from) && (h < 395);
            checkOutput($sformatf("oPIX v=%0d h=%0d", v, h), {1'b0, oPIX}, {1'b0, pe});
            checkOutput($sformatf("LSTART v=%0d h=%0d", v, h), {8'd0, LSTART}, {8'd0, (h == 395)});
            checkOutput($sformatf("OVFL v=%0d h=%0d", v, h), {8'd0, OVFL}, {8'd0, ov});
            checkOutput($sformatf("READY v=%0d h=%0d", v, h), {8'd0, READY}, 9'd1);
            if (h == 395) checkOutput($sformatf("oLINE v=%0d", v), oLINE, 9'((v + 2) % 256));
        end
        sched.delete();
    endtask

    initial begin
        RST_N  = 1'b0;
        HPOS   = 9'd395;
        VPOS   = 9'd0;
        WR_EN  = 1'b0;
        WR_X   = 9'd0;
        WR_COL = 8'd0;
        clearExp();
        applyStimulus(395, 0, 1'b0, 9'd0, 8'd0);
        applyStimulus(395, 0, 1'b0, 9'd0, 8'd0);
        checkOutput("reset oPIX", {1'b0, oPIX}, 9'd0);
        checkOutput("reset LSTART", {8'd0, LSTART}, 9'd0);
        checkOutput("reset oLINE", oLINE, 9'd0);
        checkOutput("reset READY", {8'd0, READY}, 9'd0);
        checkOutput("reset OVFL", {8'd0, OVFL}, 9'd0);

        // Clear sweep with HPOS parked on LINE_END and writes offered: no LSTART, no stored write.
        RST_N = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            applyStimulus(395, 20, 1'b1, 9'd3, 8'h7E);
            checkOutput($sformatf("clear READY c=%0d", i), {8'd0, READY}, {8'd0, (i == 256)});
            checkOutput($sformatf("clear LSTART c=%0d", i), {8'd0, LSTART}, 9'd0);
            checkOutput($sformatf("clear oPIX c=%0d", i), {1'b0, oPIX}, 9'd0);
        end

        $display("[TB] line A: writes into back bank, swap with VPOS=20");
        clearExp();
        addWrite(5, 9'd10, 8'h35);
        addWrite(20, 9'd50, 8'h11);
        addWrite(21, 9'd50, 8'h22);
        addWrite(22, 9'd50, 8'h00);
        addWrite(30, 9'd300, 8'h44);
        addWrite(395, 9'd80, 8'h5A);
        doLine(20, 395);

        $display("[TB] line B: display written pixels");
        clearExp();
        exp_pix[10] = 8'h35;
        exp_pix[50] = 8'h11;
        exp_pix[80] = 8'h5A;
        doLine(21, 395);

        clearExp();
        doLine(22, 395);

        $display("[TB] line D: cleared-on-read bank, VPOS=255 wraps oLINE");
        clearExp();
        addWrite(40, 9'd100, 8'h66);
        addWrite(41, 9'd220, 8'h99);
        doLine(255, 395);

        $display("[TB] line E: reset asserted at HPOS=200");
        clearExp();
        exp_pix[100] = 8'h66;
        addWrite(3, 9'd7, 8'h77);
        doLine(30, 199);
        RST_N = 1'b0;
        applyStimulus(200, 30, 1'b0, 9'd0, 8'd0);
        checkOutput("midline reset oPIX", {1'b0, oPIX}, 9'd0);
        checkOutput("midline reset READY", {8'd0, READY}, 9'd0);
        checkOutput("midline reset oLINE", oLINE, 9'd0);
        checkOutput("midline reset LSTART", {8'd0, LSTART}, 9'd0);
        applyStimulus(201, 30, 1'b0, 9'd0, 8'd0);
        RST_N = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            applyStimulus(0, 30, 1'b0, 9'd0, 8'd0);
            checkOutput($sformatf("reclear READY c=%0d", i), {8'd0, READY}, {8'd0, (i == 256)});
        end

        $display("[TB] lines F/G: buffers empty after reset, write-limit behaviour");
        clearExp();
        for (int k = 1; k <= 6; k++) addWrite(9 + k, 9'(k), 8'(8'h20 + k));
`ifdef LINEBUF_OVFL_EN
        ovfl_from = 14;
`endif
        doLine(40, 395);

        clearExp();
        exp_pix[1] = 8'h21;
        exp_pix[2] = 8'h22;
        exp_pix[3] = 8'h23;
        exp_pix[4] = 8'h24;
`ifndef LINEBUF_OVFL_EN
        exp_pix[5] = 8'h25;
        exp_pix[6] = 8'h26;
`endif
        doLine(41, 395);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
